// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the dmem arbiter: FSM state encoding,
// port identifiers, default widths and the read-return tag format.
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    LOCK1 = 2'd3
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 32;

  // One read-return slot: whether a read is in flight and which port issued it.
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

endpackage

// File: rtl/dmem_tag_pipe.sv
// Shift register carrying read-return tags alongside the dmem read latency,
// so the returning data can be steered to the port that issued the read.
module dmem_tag_pipe
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t stage [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port dmem: round-robin with bounded
// hold, optional port-1 burst lock, registered issue and tagged read return.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int READ_LATENCY = 1,
  parameter int MAX_HOLD     = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wren0,
  input  logic              wren1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem,
  output arb_state_t        arb_state
);

  // Handshake: a requester holds req/wren/addr/wdata stable until it sees its
  // gnt; a transfer occurs in every cycle where req and gnt are both high.

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  arb_state_t state, state_next;
  logic [7:0] hold_cnt, hold_next, hold_inc;
  logic       g0, g1;

  assign hold_inc  = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 8'd1;
  assign arb_state = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      hold_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      hold_cnt <= hold_next;
    end
  end

  // hold_cnt includes the grant being made, so a fresh owner starts at 1.
  always_comb begin
    state_next = state;
    hold_next  = 8'd0;
    if (state == LOCK1) begin
      if (g1 && !lock1) begin
        state_next = OWN1;
        hold_next  = req0 ? 8'd1 : 8'd0;
      end
    end else if (g1) begin
      state_next = lock1 ? LOCK1 : OWN1;
      if (!lock1 && req0) begin
        hold_next = (state == OWN1) ? hold_inc : 8'd1;
      end
    end else if (g0) begin
      state_next = OWN0;
      if (req1) begin
        hold_next = (state == OWN0) ? hold_inc : 8'd1;
      end
    end else begin
      state_next = IDLE;
    end
  end

  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    unique case (state)
      LOCK1: g1 = req1;
      OWN0: begin
        if (req0 && req1) begin
          g0 = (hold_cnt < HOLD_MAX);
          g1 = !g0;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
      OWN1: begin
        if (req0 && req1) begin
          g1 = (hold_cnt < HOLD_MAX);
          g0 = !g1;
        end else begin
          g0 = req0;
          g1 = req1;
        end
      end
      default: begin
        g0 = req0;
        g1 = req1 && !req0;
      end
    endcase
  end

  // Grants are combinational, so they are forced low while reset is held.
  assign gnt0 = g0 && reset;
  assign gnt1 = g1 && reset;

  tag_t issue_tag, ret_tag;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      address_dmem <= '0;
      data         <= '0;
      wren         <= 1'b0;
      issue_tag    <= '0;
    end else begin
      wren            <= (gnt0 && wren0) || (gnt1 && wren1);
      issue_tag.valid <= (gnt0 && !wren0) || (gnt1 && !wren1);
      issue_tag.port  <= gnt1 ? PORT_DBG : PORT_CPU;
      if (gnt0) begin
        address_dmem <= addr0;
        data         <= wdata0;
      end else if (gnt1) begin
        address_dmem <= addr1;
        data         <= wdata1;
      end
    end
  end

  dmem_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_tag_pipe (
    .clock  (clock),
    .reset  (reset),
    .tag_in (issue_tag),
    .tag_out(ret_tag)
  );

  logic [DATA_W-1:0] rdata0_q, rdata1_q;

  assign rvalid0 = ret_tag.valid && (ret_tag.port == PORT_CPU);
  assign rvalid1 = ret_tag.valid && (ret_tag.port == PORT_DBG);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= q_dmem;
      if (rvalid1) rdata1_q <= q_dmem;
    end
  end

  assign rdata0 = rvalid0 ? q_dmem : rdata0_q;
  assign rdata1 = rvalid1 ? q_dmem : rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with READ_LATENCY=1 and one
// with READ_LATENCY=3 share stimulus, each backed by its own write-first dmem.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int MH = 3;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          req0, req1, wren0, wren1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;

  logic          a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_wren;
  logic [DW-1:0] a_rdata0, a_rdata1, a_data, q_a;
  logic [AW-1:0] a_address_dmem;
  arb_state_t    a_arb_state;

  logic          b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_wren;
  logic [DW-1:0] b_rdata0, b_rdata1, b_data, q_b;
  logic [AW-1:0] b_address_dmem;
  arb_state_t    b_arb_state;

  int checks = 0;
  int passed = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MAX_HOLD(MH)) dut_a (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .wren0(wren0), .wren1(wren1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock1(lock1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
    .rdata0(a_rdata0), .rdata1(a_rdata1), .address_dmem(a_address_dmem), .data(a_data),
    .wren(a_wren), .q_dmem(q_a), .arb_state(a_arb_state)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(3), .MAX_HOLD(MH)) dut_b (
    .clock(clock), .reset(reset), .req0(req0), .req1(req1), .wren0(wren0), .wren1(wren1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1), .lock1(lock1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .rdata0(b_rdata0), .rdata1(b_rdata1), .address_dmem(b_address_dmem), .data(b_data),
    .wren(b_wren), .q_dmem(q_b), .arb_state(b_arb_state)
  );

  // Write-first dmem models with 1 and 3 cycles of read latency.
  logic [DW-1:0] mem_a [4096];
  logic [DW-1:0] mem_b [4096];
  logic [DW-1:0] qp_a;
  logic [DW-1:0] qp_b [3];

  always @(posedge clock) begin
    if (a_wren) mem_a[a_address_dmem] <= a_data;
    qp_a <= a_wren ? a_data : mem_a[a_address_dmem];
    if (b_wren) mem_b[b_address_dmem] <= b_data;
    qp_b[0] <= b_wren ? b_data : mem_b[b_address_dmem];
    qp_b[1] <= qp_b[0];
    qp_b[2] <= qp_b[1];
  end

  assign q_a = qp_a;
  assign q_b = qp_b[2];

  function automatic logic [DW-1:0] pre_val(int i);
    return (i == 5) ? 32'h1234_5678 : 32'hA000_0000 + 32'(i);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(int n);
    req0 = 1'b0; req1 = 1'b0; wren0 = 1'b0; wren1 = 1'b0; lock1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; wren0 = 1'b0; wren1 = 1'b0; lock1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    #1 reset = 1'b0;
    req0 = 1'b1;
    #1;
    checks++; if (a_gnt0 !== 1'b0) $display("FAIL reset_gnt0: got %b want 0", a_gnt0); else passed++;
    checks++; if (a_wren !== 1'b0) $display("FAIL reset_wren: got %b want 0", a_wren); else passed++;
    checks++; if (a_address_dmem !== 12'h000) $display("FAIL reset_addr: got %h want 000", a_address_dmem); else passed++;
    checks++; if (a_rvalid0 !== 1'b0 || a_rvalid1 !== 1'b0) $display("FAIL reset_rvalid: got %b%b want 00", a_rvalid0, a_rvalid1); else passed++;
    checks++; if (a_rdata0 !== 32'h0 || a_data !== 32'h0) $display("FAIL reset_data: got %h/%h want 0/0", a_rdata0, a_data); else passed++;
    checks++; if (a_arb_state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", a_arb_state); else passed++;
    req0 = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic preload();
    for (int i = 1; i <= 5; i++) begin
      req1 = 1'b1; wren1 = 1'b1; addr1 = 12'(i); wdata1 = pre_val(i);
      tick();
    end
    idle(3);
  endtask

  task automatic test_single_read();
    logic seen_rv1;
    seen_rv1 = 1'b0;
    req0 = 1'b1; wren0 = 1'b0; addr0 = 12'h005;
    @(negedge clock);
    seen_rv1 |= a_rvalid1;
    checks++; if (a_gnt0 !== 1'b1 || a_gnt1 !== 1'b0) $display("FAIL single_gnt: got %b%b want 10", a_gnt0, a_gnt1); else passed++;
    tick();
    req0 = 1'b0;
    @(negedge clock);
    seen_rv1 |= a_rvalid1;
    checks++; if (a_address_dmem !== 12'h005) $display("FAIL single_addr: got %h want 005", a_address_dmem); else passed++;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL single_early_rvalid: got %b want 0", a_rvalid0); else passed++;
    tick();
    @(negedge clock);
    seen_rv1 |= a_rvalid1;
    checks++; if (a_rvalid0 !== 1'b1) $display("FAIL single_rvalid: got %b want 1", a_rvalid0); else passed++;
    checks++; if (a_rdata0 !== 32'h1234_5678) $display("FAIL single_rdata: got %h want 12345678", a_rdata0); else passed++;
    tick();
    @(negedge clock);
    seen_rv1 |= a_rvalid1;
    checks++; if (a_rvalid0 !== 1'b0) $display("FAIL single_pulse_end: got %b want 0", a_rvalid0); else passed++;
    checks++; if (a_rdata0 !== 32'h1234_5678) $display("FAIL single_rdata_hold: got %h want 12345678", a_rdata0); else passed++;
    checks++; if (seen_rv1 !== 1'b0) $display("FAIL single_rvalid1: got %b want 0", seen_rv1); else passed++;
    idle(3);
  endtask

  task automatic test_round_robin();
    logic exp1;
    req0 = 1'b1; req1 = 1'b1; wren0 = 1'b0; wren1 = 1'b0; addr0 = 12'h001; addr1 = 12'h002;
    for (int i = 0; i < 9; i++) begin
      exp1 = ((i / 3) % 2) == 1;
      @(negedge clock);
      checks++;
      if (a_gnt0 !== !exp1 || a_gnt1 !== exp1)
        $display("FAIL rr_cycle%0d: got gnt0=%b gnt1=%b want gnt0=%b gnt1=%b", i, a_gnt0, a_gnt1, !exp1, exp1);
      else passed++;
      tick();
    end
    idle(6);
  endtask

  task automatic test_lock();
    logic found;
    req1 = 1'b1; wren1 = 1'b1; addr1 = 12'h010; wdata1 = 32'hDEAD_BEEF; lock1 = 1'b1;
    @(negedge clock);
    checks++; if (a_gnt1 !== 1'b1) $display("FAIL lock_first_gnt1: got %b want 1", a_gnt1); else passed++;
    tick();
    req0 = 1'b1; wren0 = 1'b0; addr0 = 12'h010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (a_gnt0 !== 1'b0 || a_gnt1 !== 1'b1 || a_arb_state !== LOCK1)
        $display("FAIL lock_hold%0d: got gnt0=%b gnt1=%b state=%0d want 0 1 LOCK1", i, a_gnt0, a_gnt1, a_arb_state);
      else passed++;
      tick();
    end
    lock1 = 1'b0;
    @(negedge clock);
    checks++; if (a_gnt1 !== 1'b1 || a_gnt0 !== 1'b0) $display("FAIL lock_release: got gnt0=%b gnt1=%b want 0 1", a_gnt0, a_gnt1); else passed++;
    tick();
    found = 1'b0;
    for (int i = 0; i < MH + 1 && !found; i++) begin
      @(negedge clock);
      if (a_gnt0 === 1'b1) found = 1'b1;
      else tick();
    end
    checks++; if (found !== 1'b1) $display("FAIL lock_gnt0_bound: got no gnt0 within %0d cycles, want one", MH + 1); else passed++;
    tick();
    req0 = 1'b0; req1 = 1'b0; wren1 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clock);
      if (a_rvalid0 === 1'b1) found = 1'b1;
      else tick();
    end
    checks++; if (found !== 1'b1) $display("FAIL lock_read_timeout: got no rvalid0 within 4 cycles, want one"); else passed++;
    checks++; if (a_rdata0 !== 32'hDEAD_BEEF) $display("FAIL lock_read_data: got %h want deadbeef", a_rdata0); else passed++;
    idle(6);
  endtask

  task automatic test_pipelined();
    logic ev0, ev1;
    for (int i = 0; i < 10; i++) begin
      req0 = (i < 4) && (i % 2 == 0);
      req1 = (i < 4) && (i % 2 == 1);
      wren0 = 1'b0; wren1 = 1'b0;
      addr0 = 12'(i + 1); addr1 = 12'(i + 1);
      ev0 = (i == 4) || (i == 6);
      ev1 = (i == 5) || (i == 7);
      @(negedge clock);
      checks++;
      if (b_rvalid0 !== ev0 || b_rvalid1 !== ev1)
        $display("FAIL pipe_rvalid%0d: got %b%b want %b%b", i, b_rvalid0, b_rvalid1, ev0, ev1);
      else passed++;
      if (ev0) begin
        checks++; if (b_rdata0 !== pre_val(i - 3)) $display("FAIL pipe_rdata0_%0d: got %h want %h", i, b_rdata0, pre_val(i - 3)); else passed++;
      end
      if (ev1) begin
        checks++; if (b_rdata1 !== pre_val(i - 3)) $display("FAIL pipe_rdata1_%0d: got %h want %h", i, b_rdata1, pre_val(i - 3)); else passed++;
      end
      tick();
    end
    idle(2);
  endtask

  task automatic test_write_read();
    req0 = 1'b1; wren0 = 1'b1; addr0 = 12'h020; wdata0 = 32'hCAFE_F00D;
    @(negedge clock);
    checks++; if (a_gnt0 !== 1'b1) $display("FAIL wr_gnt: got %b want 1", a_gnt0); else passed++;
    tick();
    wren0 = 1'b0;
    @(negedge clock);
    checks++;
    if (a_wren !== 1'b1 || a_address_dmem !== 12'h020 || a_data !== 32'hCAFE_F00D)
      $display("FAIL wr_issue: got wren=%b addr=%h data=%h want 1 020 cafef00d", a_wren, a_address_dmem, a_data);
    else passed++;
    tick();
    req0 = 1'b0;
    @(negedge clock);
    checks++; if (a_wren !== 1'b0) $display("FAIL wr_one_cycle: got %b want 0", a_wren); else passed++;
    tick();
    @(negedge clock);
    checks++; if (a_rvalid0 !== 1'b1) $display("FAIL wr_read_rvalid: got %b want 1", a_rvalid0); else passed++;
    checks++; if (a_rdata0 !== 32'hCAFE_F00D) $display("FAIL wr_read_data: got %h want cafef00d", a_rdata0); else passed++;
    idle(5);
  endtask

  task automatic test_reset_inflight();
    logic ea, eb;
    req0 = 1'b1; wren0 = 1'b0; addr0 = 12'h001;
    tick();
    req0 = 1'b0; req1 = 1'b1; wren1 = 1'b0; addr1 = 12'h002;
    #2 reset = 1'b0;
    #1;
    checks++; if (a_gnt1 !== 1'b0 || b_gnt1 !== 1'b0) $display("FAIL rst_async_gnt: got %b%b want 00", a_gnt1, b_gnt1); else passed++;
    checks++; if (a_address_dmem !== 12'h000 || a_data !== 32'h0) $display("FAIL rst_async_issue: got %h/%h want 000/0", a_address_dmem, a_data); else passed++;
    checks++; if (a_rdata0 !== 32'h0 || b_rdata1 !== 32'h0) $display("FAIL rst_async_rdata: got %h/%h want 0/0", a_rdata0, b_rdata1); else passed++;
    checks++; if (a_arb_state !== IDLE) $display("FAIL rst_async_state: got %0d want IDLE", a_arb_state); else passed++;
    req1 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    req0 = 1'b1; wren0 = 1'b0; addr0 = 12'h003;
    @(negedge clock);
    checks++; if (a_gnt0 !== 1'b1) $display("FAIL rst_first_grant: got %b want 1", a_gnt0); else passed++;
    tick();
    req0 = 1'b0;
    for (int r = 1; r <= 6; r++) begin
      ea = (r == 2);
      eb = (r == 4);
      @(negedge clock);
      checks++;
      if (a_rvalid0 !== ea || a_rvalid1 !== 1'b0 || b_rvalid0 !== eb || b_rvalid1 !== 1'b0)
        $display("FAIL rst_stale%0d: got a=%b%b b=%b%b want a=%b0 b=%b0", r, a_rvalid0, a_rvalid1, b_rvalid0, b_rvalid1, ea, eb);
      else passed++;
      if (ea) begin
        checks++; if (a_rdata0 !== pre_val(3)) $display("FAIL rst_new_read_a: got %h want %h", a_rdata0, pre_val(3)); else passed++;
      end
      if (eb) begin
        checks++; if (b_rdata0 !== pre_val(3)) $display("FAIL rst_new_read_b: got %h want %h", b_rdata0, pre_val(3)); else passed++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    preload();
    test_single_read();
    test_round_robin();
    test_lock();
    test_pipelined();
    test_write_read();
    test_reset_inflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
